// File: rtl/lxcache_mem_intf_pkg.sv
// Shared message encodings, FSM state type and helper functions for the Lx cache
// memory-side interface.
package lxcache_mem_intf_pkg;

    localparam int MSG_W = 4;

    localparam logic [MSG_W-1:0] NO_REQ     = 4'd0;
    localparam logic [MSG_W-1:0] R_REQ      = 4'd1;
    localparam logic [MSG_W-1:0] WB_REQ     = 4'd2;
    localparam logic [MSG_W-1:0] C_FLUSH    = 4'd3;
    localparam logic [MSG_W-1:0] REQ_FLUSH  = 4'd4;
    localparam logic [MSG_W-1:0] INV        = 4'd5;
    localparam logic [MSG_W-1:0] MEM_RESP   = 4'd6;
    localparam logic [MSG_W-1:0] MEM_RESP_S = 4'd7;
    localparam logic [MSG_W-1:0] MEM_C_RESP = 4'd8;

    typedef enum logic [2:0] {
        IDLE,
        REQ_OUT,
        BACKOFF,
        RESP,
        WAIT_CLEAR,
        EXT_FWD,
        EXT_REPLY
    } state_t;

    function automatic logic is_response(input logic [MSG_W-1:0] msg);
        return (msg == MEM_RESP) || (msg == MEM_RESP_S) || (msg == MEM_C_RESP);
    endfunction

    // Ceiling log2, usable in constant expressions.
    function automatic int log2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) result = i + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/lxcache_mem_intf_if.sv
// Bundle of controller-side and next-level-side signals of the Lx cache memory interface.
interface lxcache_mem_intf_if #(
    parameter int MSG_BITS     = 4,
    parameter int ADDRESS_BITS = 32,
    parameter int CACHE_WIDTH  = 32
);
    logic [MSG_BITS-1:0]     cache2mem_msg;
    logic [ADDRESS_BITS-1:0] cache2mem_address;
    logic [CACHE_WIDTH-1:0]  cache2mem_data;
    logic [MSG_BITS-1:0]     mem2cache_msg;
    logic [ADDRESS_BITS-1:0] mem2cache_address;
    logic [CACHE_WIDTH-1:0]  mem2cache_data;
    logic                    mem_intf_busy;
    logic [ADDRESS_BITS-1:0] mem_intf_address;
    logic                    mem_intf_address_valid;
    logic [MSG_BITS-1:0]     mem_msg_out;
    logic [ADDRESS_BITS-1:0] mem_address_out;
    logic [CACHE_WIDTH-1:0]  mem_data_out;
    logic [MSG_BITS-1:0]     mem_msg_in;
    logic [ADDRESS_BITS-1:0] mem_address_in;
    logic [CACHE_WIDTH-1:0]  mem_data_in;

    // The environment (controller plus next level) drives the master side.
    modport master (
        output cache2mem_msg, cache2mem_address, cache2mem_data,
        output mem_msg_in, mem_address_in, mem_data_in,
        input  mem2cache_msg, mem2cache_address, mem2cache_data,
        input  mem_intf_busy, mem_intf_address, mem_intf_address_valid,
        input  mem_msg_out, mem_address_out, mem_data_out
    );

    modport slave (
        input  cache2mem_msg, cache2mem_address, cache2mem_data,
        input  mem_msg_in, mem_address_in, mem_data_in,
        output mem2cache_msg, mem2cache_address, mem2cache_data,
        output mem_intf_busy, mem_intf_address, mem_intf_address_valid,
        output mem_msg_out, mem_address_out, mem_data_out
    );

endinterface

// File: rtl/lxcache_mem_intf_reissue_timer.sv
// Saturating cycle counter that flags when an outstanding request should be reissued.
module lxcache_reissue_timer
    import lxcache_mem_intf_pkg::*;
#(
    parameter int REISSUE_COUNT = 100
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = log2(REISSUE_COUNT + 1);
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(REISSUE_COUNT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] count;

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable && (count != CNT_MAX)) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == LAST);

endmodule

// File: rtl/lxcache_mem_intf.sv
// Memory-side interface of the Lx cache: one outstanding controller request with
// timeout reissue, plus relay of downstream coherence requests and their replies.
module lxcache_mem_intf
    import lxcache_mem_intf_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int OFFSET_BITS   = 2,
    parameter int ADDRESS_BITS  = 32,
    parameter int MSG_BITS      = 4,
    parameter int REISSUE_COUNT = 100
) (
    input logic               clock,
    input logic               reset,
    lxcache_mem_intf_if.slave bus
);

    localparam int CACHE_WIDTH = DATA_WIDTH << OFFSET_BITS;

    state_t state, state_d;
    logic   expired;

    logic [MSG_BITS-1:0]     req_msg, req_msg_d, ext_msg, ext_msg_d, ans_msg, ans_msg_d;
    logic [ADDRESS_BITS-1:0] req_addr, req_addr_d, ext_addr, ext_addr_d, ans_addr, ans_addr_d;
    logic [CACHE_WIDTH-1:0]  req_data, req_data_d, ext_data, ext_data_d, ans_data, ans_data_d;

    logic [MSG_BITS-1:0]     m2c_msg_d, out_msg_d;
    logic [ADDRESS_BITS-1:0] m2c_addr_d, out_addr_d, intf_addr_d;
    logic [CACHE_WIDTH-1:0]  m2c_data_d, out_data_d;
    logic                    busy_d, valid_d;

    lxcache_reissue_timer #(.REISSUE_COUNT(REISSUE_COUNT)) reissue_timer (
        .clock   (clock),
        .reset   (reset),
        .clear   (state != REQ_OUT),
        .enable  (state == REQ_OUT),
        .expired (expired)
    );

    always_comb begin
        state_d    = state;
        req_msg_d  = req_msg;
        req_addr_d = req_addr;
        req_data_d = req_data;
        ext_msg_d  = ext_msg;
        ext_addr_d = ext_addr;
        ext_data_d = ext_data;
        ans_msg_d  = ans_msg;
        ans_addr_d = ans_addr;
        ans_data_d = ans_data;

        case (state)
            IDLE: begin
                if ((bus.mem_msg_in != NO_REQ) && !is_response(bus.mem_msg_in)) begin
                    ext_msg_d  = bus.mem_msg_in;
                    ext_addr_d = bus.mem_address_in;
                    ext_data_d = bus.mem_data_in;
                    state_d    = EXT_FWD;
                end else if (bus.cache2mem_msg != NO_REQ) begin
                    req_msg_d  = bus.cache2mem_msg;
                    req_addr_d = bus.cache2mem_address;
                    req_data_d = bus.cache2mem_data;
                    state_d    = REQ_OUT;
                end
            end
            REQ_OUT: begin
                // A matching response wins over a timeout in the same cycle.
                if (is_response(bus.mem_msg_in) && (bus.mem_address_in == req_addr)) begin
                    ans_msg_d  = bus.mem_msg_in;
                    ans_addr_d = req_addr;
                    ans_data_d = bus.mem_data_in;
                    state_d    = RESP;
                end else if (expired) begin
                    state_d = BACKOFF;
                end
            end
            BACKOFF:    state_d = REQ_OUT;
            RESP:       state_d = WAIT_CLEAR;
            WAIT_CLEAR: if (bus.cache2mem_msg == NO_REQ) state_d = IDLE;
            EXT_FWD: begin
                if ((bus.cache2mem_msg != NO_REQ) && (bus.cache2mem_address == ext_addr)) begin
                    ans_msg_d  = bus.cache2mem_msg;
                    ans_addr_d = bus.cache2mem_address;
                    ans_data_d = bus.cache2mem_data;
                    state_d    = EXT_REPLY;
                end
            end
            EXT_REPLY: begin
                if ((bus.mem_msg_in != ext_msg) || (bus.mem_address_in != ext_addr))
                    state_d = WAIT_CLEAR;
            end
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state so they appear right after the deciding edge.
        m2c_msg_d   = NO_REQ;
        m2c_addr_d  = '0;
        m2c_data_d  = '0;
        out_msg_d   = NO_REQ;
        out_addr_d  = '0;
        out_data_d  = '0;
        intf_addr_d = '0;
        valid_d     = 1'b0;
        busy_d      = (state_d != IDLE);

        case (state_d)
            REQ_OUT: begin
                out_msg_d   = req_msg_d;
                out_addr_d  = req_addr_d;
                out_data_d  = req_data_d;
                intf_addr_d = req_addr_d;
                valid_d     = 1'b1;
            end
            BACKOFF: begin
                intf_addr_d = req_addr_d;
                valid_d     = 1'b1;
            end
            RESP: begin
                m2c_msg_d   = ans_msg_d;
                m2c_addr_d  = ans_addr_d;
                m2c_data_d  = ans_data_d;
                intf_addr_d = req_addr_d;
                valid_d     = 1'b1;
            end
            EXT_FWD: begin
                m2c_msg_d   = ext_msg_d;
                m2c_addr_d  = ext_addr_d;
                m2c_data_d  = ext_data_d;
                intf_addr_d = ext_addr_d;
                valid_d     = 1'b1;
            end
            EXT_REPLY: begin
                out_msg_d   = ans_msg_d;
                out_addr_d  = ans_addr_d;
                out_data_d  = ans_data_d;
                intf_addr_d = ext_addr_d;
                valid_d     = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state                      <= IDLE;
            req_msg                    <= NO_REQ;
            req_addr                   <= '0;
            req_data                   <= '0;
            ext_msg                    <= NO_REQ;
            ext_addr                   <= '0;
            ext_data                   <= '0;
            ans_msg                    <= NO_REQ;
            ans_addr                   <= '0;
            ans_data                   <= '0;
            bus.mem2cache_msg          <= NO_REQ;
            bus.mem2cache_address      <= '0;
            bus.mem2cache_data         <= '0;
            bus.mem_msg_out            <= NO_REQ;
            bus.mem_address_out        <= '0;
            bus.mem_data_out           <= '0;
            bus.mem_intf_address       <= '0;
            bus.mem_intf_address_valid <= 1'b0;
            bus.mem_intf_busy          <= 1'b0;
        end else begin
            state                      <= state_d;
            req_msg                    <= req_msg_d;
            req_addr                   <= req_addr_d;
            req_data                   <= req_data_d;
            ext_msg                    <= ext_msg_d;
            ext_addr                   <= ext_addr_d;
            ext_data                   <= ext_data_d;
            ans_msg                    <= ans_msg_d;
            ans_addr                   <= ans_addr_d;
            ans_data                   <= ans_data_d;
            bus.mem2cache_msg          <= m2c_msg_d;
            bus.mem2cache_address      <= m2c_addr_d;
            bus.mem2cache_data         <= m2c_data_d;
            bus.mem_msg_out            <= out_msg_d;
            bus.mem_address_out        <= out_addr_d;
            bus.mem_data_out           <= out_data_d;
            bus.mem_intf_address       <= intf_addr_d;
            bus.mem_intf_address_valid <= valid_d;
            bus.mem_intf_busy          <= busy_d;
        end
    end

endmodule
